// File: rtl/eq_seq_pkg.sv
// Shared definitions for the EQ parameter sequencer.
// Contents:
//   state_t      - sequencer FSM encoding (IDLE / SCAN / WRITE)
//   gain_t       - 16-bit signed two's-complement gain
//   NBAND_DEF    - default number of EQ bands
//   GAIN_MAX_DEF - default upper gain clamp
//   GAIN_MIN_DEF - default lower gain clamp
package eq_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  typedef logic signed [15:0] gain_t;

  localparam int NBAND_DEF    = 7;
  localparam int GAIN_MAX_DEF = 12;
  localparam int GAIN_MIN_DEF = -11;

endpackage

// File: rtl/eq_gain_stepper.sv
// Pure combinational gain arithmetic for the EQ sequencer.
// Build option: EQ_SEQ_RAMP_EN selects +/-1 ramping; otherwise the
// current gain jumps straight to the target.
// Ports:
//   i_raw     - raw requested target gain
//   o_clamped - i_raw clamped to [GAIN_MIN, GAIN_MAX]
//   i_cur     - current gain of the band being scanned
//   i_tgt     - target gain of the band being scanned
//   o_next    - current gain after one step toward the target
module eq_gain_stepper
  import eq_seq_pkg::*;
#(
  parameter int GAIN_MAX = GAIN_MAX_DEF,
  parameter int GAIN_MIN = GAIN_MIN_DEF
) (
  input  logic signed [15:0] i_raw,
  output logic signed [15:0] o_clamped,
  input  logic signed [15:0] i_cur,
  input  logic signed [15:0] i_tgt,
  output logic signed [15:0] o_next
);

  function automatic gain_t clamp_gain(input gain_t raw);
    gain_t res;
    if (raw > gain_t'(GAIN_MAX)) begin
      res = gain_t'(GAIN_MAX);
    end else if (raw < gain_t'(GAIN_MIN)) begin
      res = gain_t'(GAIN_MIN);
    end else begin
      res = raw;
    end
    return res;
  endfunction

  function automatic gain_t step_toward(input gain_t cur, input gain_t tgt);
    gain_t res;
`ifdef EQ_SEQ_RAMP_EN
    if (tgt > cur) begin
      res = cur + 16'sd1;
    end else if (tgt < cur) begin
      res = cur - 16'sd1;
    end else begin
      res = cur;
    end
`else
    // Jump mode: the write carries the target directly.
    res = (cur == tgt) ? cur : tgt;
`endif
    return res;
  endfunction

  // Clamp and step results for the sequencer datapath
  always_comb begin
    o_clamped = clamp_gain(i_raw);
    o_next    = step_toward(i_cur, i_tgt);
  end

endmodule

// File: rtl/eq_param_sequencer.sv
// EQ parameter sequencer: holds per-band target/current gains and, on
// each audio frame tick, walks the bands and issues one DSP write per
// band whose current gain differs from its target.
// Build option: EQ_SEQ_RAMP_EN (see eq_gain_stepper) enables +/-1 ramping.
// Ports:
//   i_clk, i_rst_n        - clock, asynchronous active-low reset
//   i_frame_tick          - one pulse per audio sample; starts a scan pass
//   i_tgt_wr/band/gain    - load a (clamped) target gain for one band
//   i_clear               - zero all targets (wins over i_tgt_wr)
//   o_wr_valid/i_wr_ready - DSP write handshake, o_band/o_gain payload
//   o_settled             - idle and every current gain equals its target
//   o_overrun             - sticky: a frame tick was lost
module eq_param_sequencer
  import eq_seq_pkg::*;
#(
  parameter int NBAND    = NBAND_DEF,
  parameter int GAIN_MAX = GAIN_MAX_DEF,
  parameter int GAIN_MIN = GAIN_MIN_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_frame_tick,
  input  logic        i_tgt_wr,
  input  logic [2:0]  i_tgt_band,
  input  logic [15:0] i_tgt_gain,
  input  logic        i_clear,
  output logic        o_wr_valid,
  input  logic        i_wr_ready,
  output logic [2:0]  o_band,
  output logic [15:0] o_gain,
  output logic        o_settled,
  output logic        o_overrun
);

  state_t     state_r, state_nx_s;
  logic [2:0] band_r, band_nx_s;
  logic       pending_r, overrun_r;
  logic       wr_valid_r;
  logic [2:0] band_out_r;
  gain_t      gain_out_r;
  gain_t      tgt_r [NBAND];
  gain_t      cur_r [NBAND];

  gain_t      cur_sel_s, tgt_sel_s, next_s, clamped_s;
  logic       mismatch_s, last_band_s, band_ok_s, tick_busy_s;
  logic       start_s, step_s, xfer_s, all_eq_s;

  eq_gain_stepper #(
    .GAIN_MAX (GAIN_MAX),
    .GAIN_MIN (GAIN_MIN)
  ) u_stepper (
    .i_raw     (gain_t'(i_tgt_gain)),
    .o_clamped (clamped_s),
    .i_cur     (cur_sel_s),
    .i_tgt     (tgt_sel_s),
    .o_next    (next_s)
  );

  // Band selection and status decode
  always_comb begin
    cur_sel_s   = cur_r[band_r];
    tgt_sel_s   = tgt_r[band_r];
    mismatch_s  = (cur_sel_s != tgt_sel_s);
    last_band_s = (band_r == 3'(NBAND - 1));
    band_ok_s   = ({29'd0, i_tgt_band} < 32'(NBAND));
    tick_busy_s = i_frame_tick && (state_r != ST_IDLE);
    all_eq_s    = 1'b1;
    for (int i = 0; i < NBAND; i++) begin
      all_eq_s = all_eq_s & (cur_r[i] == tgt_r[i]);
    end
  end

  // FSM next-state logic and datapath enables
  always_comb begin
    state_nx_s = state_r;
    band_nx_s  = band_r;
    start_s    = 1'b0;
    step_s     = 1'b0;
    xfer_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_frame_tick || pending_r) begin
          state_nx_s = ST_SCAN;
          band_nx_s  = 3'd0;
          start_s    = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (mismatch_s) begin
          state_nx_s = ST_WRITE;
          step_s     = 1'b1;
        end else if (last_band_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          band_nx_s  = band_r + 3'd1;
        end
      end
      ST_WRITE: begin
        if (i_wr_ready) begin
          xfer_s = 1'b1;
          if (last_band_s) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_SCAN;
            band_nx_s  = band_r + 3'd1;
          end
        end else begin
          state_nx_s = ST_WRITE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        band_nx_s  = 3'd0;
      end
    endcase
  end

  // FSM state and band index registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      band_r  <= 3'd0;
    end else begin
      state_r <= state_nx_s;
      band_r  <= band_nx_s;
    end
  end

  // One-deep tick pending flag and sticky overrun
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending_r <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (start_s) begin
        pending_r <= 1'b0;
      end else if (tick_busy_s) begin
        pending_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
      if (tick_busy_s && pending_r) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  // Target gain registers; clear has priority over a target write
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NBAND; i++) tgt_r[i] <= 16'sd0;
    end else if (i_clear) begin
      for (int i = 0; i < NBAND; i++) tgt_r[i] <= 16'sd0;
    end else if (i_tgt_wr && band_ok_s) begin
      tgt_r[i_tgt_band] <= clamped_s;
    end
  end

  // Current gain registers, advanced when a scan finds a mismatch
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NBAND; i++) cur_r[i] <= 16'sd0;
    end else if (step_s) begin
      cur_r[band_r] <= next_s;
    end
  end

  // Write request registers; payload is frozen until the transfer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_valid_r <= 1'b0;
      band_out_r <= 3'd0;
      gain_out_r <= 16'sd0;
    end else if (step_s) begin
      wr_valid_r <= 1'b1;
      band_out_r <= band_r;
      gain_out_r <= next_s;
    end else if (xfer_s) begin
      wr_valid_r <= 1'b0;
    end
  end

  assign o_wr_valid = wr_valid_r;
  assign o_band     = band_out_r;
  assign o_gain     = gain_out_r;
  assign o_overrun  = overrun_r;
  // Combinational from registers so a fresh target drops it immediately.
  assign o_settled  = (state_r == ST_IDLE) && all_eq_s;

endmodule

// File: tb/tb_eq_param_sequencer.sv
// Directed self-checking bench for eq_param_sequencer. Expected write
// sequences depend on whether EQ_SEQ_RAMP_EN is defined for the build.
module tb_eq_param_sequencer;

`ifdef EQ_SEQ_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_rst_n, i_frame_tick, i_tgt_wr, i_clear, i_wr_ready;
  logic [2:0]  i_tgt_band;
  logic [15:0] i_tgt_gain;
  logic        o_wr_valid, o_settled, o_overrun;
  logic [2:0]  o_band;
  logic [15:0] o_gain;

  int total = 0;
  int bad   = 0;
  int wb_q[$];
  int wg_q[$];
  int first_off;

  always #5 clk = ~clk;

  eq_param_sequencer dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_frame_tick (i_frame_tick),
    .i_tgt_wr     (i_tgt_wr),
    .i_tgt_band   (i_tgt_band),
    .i_tgt_gain   (i_tgt_gain),
    .i_clear      (i_clear),
    .o_wr_valid   (o_wr_valid),
    .i_wr_ready   (i_wr_ready),
    .o_band       (o_band),
    .o_gain       (o_gain),
    .o_settled    (o_settled),
    .o_overrun    (o_overrun)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    i_rst_n = 1'b0; i_frame_tick = 1'b0; i_tgt_wr = 1'b0; i_clear = 1'b0;
    i_tgt_band = 3'd0; i_tgt_gain = 16'd0; i_wr_ready = 1'b1;
    step(); step();
    i_rst_n = 1'b1;
    step();
  endtask

  task automatic pulse_tick;
    i_frame_tick = 1'b1;
    step();
    i_frame_tick = 1'b0;
  endtask

  task automatic set_tgt(input int b, input int g);
    i_tgt_wr = 1'b1; i_tgt_band = 3'(b); i_tgt_gain = 16'(g);
    step();
    i_tgt_wr = 1'b0;
  endtask

  // Record every accepted write over ncyc sampled cycles.
  task automatic collect(input int ncyc);
    wb_q.delete(); wg_q.delete(); first_off = -1;
    for (int i = 0; i < ncyc; i++) begin
      if (o_wr_valid && i_wr_ready) begin
        wb_q.push_back(int'(o_band));
        wg_q.push_back(int'($signed(o_gain)));
        if (first_off < 0) first_off = i;
      end
      step();
    end
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20; i++) begin
      if (o_wr_valid) break;
      step();
    end
    total++;
    if (o_wr_valid !== 1'b1) begin
      bad++; $display("FAIL %s_timeout: o_wr_valid=%0b expected 1", name, o_wr_valid);
    end
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0; i_frame_tick = 1'b0; i_tgt_wr = 1'b0; i_clear = 1'b0;
    i_tgt_band = 3'd0; i_tgt_gain = 16'd0; i_wr_ready = 1'b1;
    #3;
    total++;
    if ({o_wr_valid, o_band, o_gain, o_overrun} !== 21'd0) begin
      bad++; $display("FAIL reset_outputs: valid=%0b band=%0d gain=%0d ovr=%0b expected 0", o_wr_valid, o_band, o_gain, o_overrun);
    end
    step(); step();
    i_rst_n = 1'b1;
    step();
    total++;
    if (o_settled !== 1'b1) begin
      bad++; $display("FAIL reset_settled: got %0b expected 1", o_settled);
    end
  endtask

  task automatic test_ramp;
    int passes;
    apply_reset();
    set_tgt(2, 3);
    total++;
    if (o_settled !== 1'b0) begin
      bad++; $display("FAIL ramp_unsettled: got %0b expected 0", o_settled);
    end
    passes = RAMP ? 3 : 1;
    for (int p = 0; p < passes; p++) begin
      pulse_tick();
      collect(20);
      total++;
      if (wb_q.size() != 1) begin
        bad++; $display("FAIL ramp_count: pass %0d got %0d writes expected 1", p, wb_q.size());
      end
      total++;
      if (wb_q.size() < 1 || wb_q[0] != 2 || wg_q[0] != (RAMP ? p + 1 : 3)) begin
        bad++; $display("FAIL ramp_write: pass %0d got (%0d,%0d) expected (2,%0d)", p,
                        (wb_q.size() > 0) ? wb_q[0] : -1, (wg_q.size() > 0) ? wg_q[0] : -99, RAMP ? p + 1 : 3);
      end
      total++;
      if (first_off != 3) begin
        bad++; $display("FAIL ramp_latency: got offset %0d expected 3", first_off);
      end
      total++;
      if (o_settled !== (p == passes - 1)) begin
        bad++; $display("FAIL ramp_settled: pass %0d got %0b expected %0b", p, o_settled, p == passes - 1);
      end
    end
  endtask

  task automatic test_clamp;
    int passes;
    apply_reset();
    set_tgt(0, 20);
    passes = RAMP ? 12 : 1;
    for (int p = 0; p < passes; p++) begin
      pulse_tick();
      collect(20);
      total++;
      if (wb_q.size() != 1 || wb_q[0] != 0 || wg_q[0] != (RAMP ? p + 1 : 12) || first_off != 1) begin
        bad++; $display("FAIL clamp_hi: pass %0d got n=%0d gain=%0d off=%0d expected n=1 (0,%0d) off=1", p,
                        wb_q.size(), (wg_q.size() > 0) ? wg_q[0] : -99, first_off, RAMP ? p + 1 : 12);
      end
    end
    set_tgt(4, -30);
    passes = RAMP ? 11 : 1;
    for (int p = 0; p < passes; p++) begin
      pulse_tick();
      collect(20);
      total++;
      if (wb_q.size() != 1 || wb_q[0] != 4 || wg_q[0] != (RAMP ? -(p + 1) : -11) || first_off != 5) begin
        bad++; $display("FAIL clamp_lo: pass %0d got n=%0d gain=%0d off=%0d expected n=1 (4,%0d) off=5", p,
                        wb_q.size(), (wg_q.size() > 0) ? wg_q[0] : -99, first_off, RAMP ? -(p + 1) : -11);
      end
    end
    set_tgt(7, 5);
    total++;
    if (o_settled !== 1'b1) begin
      bad++; $display("FAIL bad_band_settled: got %0b expected 1", o_settled);
    end
    pulse_tick();
    collect(20);
    total++;
    if (wb_q.size() != 0) begin
      bad++; $display("FAIL bad_band_writes: got %0d expected 0", wb_q.size());
    end
  endtask

  task automatic test_stall;
    int exp_g;
    apply_reset();
    i_wr_ready = 1'b0;
    set_tgt(3, 4);
    exp_g = RAMP ? 1 : 4;
    pulse_tick();
    wait_valid("stall");
    set_tgt(3, -5);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (o_wr_valid !== 1'b1 || o_band !== 3'd3 || int'($signed(o_gain)) != exp_g) begin
        bad++; $display("FAIL stall_hold: cycle %0d got valid=%0b band=%0d gain=%0d expected 1,3,%0d", i,
                        o_wr_valid, o_band, $signed(o_gain), exp_g);
      end
      step();
    end
    i_wr_ready = 1'b1;
    step();
    total++;
    if (o_wr_valid !== 1'b0) begin
      bad++; $display("FAIL stall_release: valid=%0b expected 0", o_wr_valid);
    end
  endtask

  task automatic test_back_to_back;
    apply_reset();
    set_tgt(1, 2);
    set_tgt(5, -3);
    pulse_tick();
    collect(25);
    total++;
    if (wb_q.size() != 2) begin
      bad++; $display("FAIL b2b_count: got %0d expected 2", wb_q.size());
    end
    total++;
    if (wb_q.size() < 2 || wb_q[0] != 1 || wg_q[0] != (RAMP ? 1 : 2) || wb_q[1] != 5 || wg_q[1] != (RAMP ? -1 : -3)) begin
      bad++; $display("FAIL b2b_writes: got first=(%0d,%0d) expected (1,%0d),(5,%0d)",
                      (wb_q.size() > 0) ? wb_q[0] : -1, (wg_q.size() > 0) ? wg_q[0] : -99, RAMP ? 1 : 2, RAMP ? -1 : -3);
    end
  endtask

  task automatic test_overrun;
    apply_reset();
    pulse_tick();
    step();
    // Second tick arrives mid-pass, together with a target for an already-scanned band.
    i_frame_tick = 1'b1; i_tgt_wr = 1'b1; i_tgt_band = 3'd0; i_tgt_gain = 16'd5;
    step();
    i_frame_tick = 1'b0; i_tgt_wr = 1'b0;
    collect(30);
    total++;
    if (wb_q.size() != 1 || wb_q[0] != 0 || wg_q[0] != (RAMP ? 1 : 5)) begin
      bad++; $display("FAIL pending_pass: got n=%0d gain=%0d expected n=1 (0,%0d)", wb_q.size(),
                      (wg_q.size() > 0) ? wg_q[0] : -99, RAMP ? 1 : 5);
    end
    total++;
    if (o_overrun !== 1'b0) begin
      bad++; $display("FAIL overrun_two: got %0b expected 0", o_overrun);
    end
    apply_reset();
    pulse_tick(); pulse_tick(); pulse_tick();
    total++;
    if (o_overrun !== 1'b1) begin
      bad++; $display("FAIL overrun_three: got %0b expected 1", o_overrun);
    end
    collect(30);
    total++;
    if (o_overrun !== 1'b1 || o_settled !== 1'b1) begin
      bad++; $display("FAIL overrun_sticky: ovr=%0b settled=%0b expected 1,1", o_overrun, o_settled);
    end
  endtask

  task automatic test_clear;
    apply_reset();
    i_clear = 1'b1; i_tgt_wr = 1'b1; i_tgt_band = 3'd1; i_tgt_gain = 16'd5;
    step();
    i_clear = 1'b0; i_tgt_wr = 1'b0;
    total++;
    if (o_settled !== 1'b1) begin
      bad++; $display("FAIL clear_wins_settled: got %0b expected 1", o_settled);
    end
    pulse_tick();
    collect(20);
    total++;
    if (wb_q.size() != 0) begin
      bad++; $display("FAIL clear_wins_writes: got %0d expected 0", wb_q.size());
    end
    set_tgt(2, 7);
    total++;
    if (o_settled !== 1'b0) begin
      bad++; $display("FAIL clear_pre: got %0b expected 0", o_settled);
    end
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    total++;
    if (o_settled !== 1'b1) begin
      bad++; $display("FAIL clear_post: got %0b expected 1", o_settled);
    end
  endtask

  task automatic test_reset_mid_write;
    apply_reset();
    i_wr_ready = 1'b0;
    set_tgt(0, 3);
    pulse_tick();
    wait_valid("midwr");
    #2;
    i_rst_n = 1'b0;
    #1;
    total++;
    if (o_wr_valid !== 1'b0) begin
      bad++; $display("FAIL midwr_drop: valid=%0b expected 0", o_wr_valid);
    end
    step();
    i_rst_n = 1'b1; i_wr_ready = 1'b1;
    step();
    total++;
    if ({o_wr_valid, o_band, o_gain, o_overrun, o_settled} !== 22'd1) begin
      bad++; $display("FAIL midwr_outputs: valid=%0b band=%0d gain=%0d ovr=%0b settled=%0b expected 0,0,0,0,1",
                      o_wr_valid, o_band, o_gain, o_overrun, o_settled);
    end
    pulse_tick();
    collect(20);
    total++;
    if (wb_q.size() != 0) begin
      bad++; $display("FAIL midwr_retry: got %0d writes expected 0", wb_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp();
    test_clamp();
    test_stall();
    test_back_to_back();
    test_overrun();
    test_clear();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
